// File: rtl/writeback_unit.sv
// Writeback unit: delays store intents by WB_LAT cycles, commits matured stores into the
// register file, and mirrors writes to the last register into a small output FIFO.
module writeback_unit #(
    parameter int NREGS     = 32,
    parameter int WB_LAT    = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_store_in,
    input  logic [11:0] addr,
    input  logic [15:0] alu_result,
    input  logic [4:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        drop,
    output logic        overflow,
    output logic [7:0]  wb_count
);

    localparam int AW = 5;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [11:0]   NREGS_A  = 12'(NREGS);
    localparam logic [11:0]   LAST_A   = 12'(NREGS - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

    logic [WB_LAT-1:0]       st_q, st_d;
    logic [WB_LAT-1:0][11:0] ad_q, ad_d;

    logic [15:0]   regs_q [NREGS];
    logic [15:0]   fifo_q [OUT_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rd_q, rd_d;
    logic          drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    wbc_q, wbc_d;

    logic          mat_st;
    logic [11:0]   mat_ad;
    logic [AW-1:0] waddr;
    logic          in_range;
    logic          commit;
    logic          bad;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign mat_st   = st_q[WB_LAT-1];
    assign mat_ad   = ad_q[WB_LAT-1];
    assign waddr    = mat_ad[AW-1:0];
    assign in_range = mat_ad < NREGS_A;
    // Nothing commits while reset is asserted, even a store maturing on that edge.
    assign commit   = rst && mat_st && in_range;
    assign bad      = rst && mat_st && !in_range;
    assign push     = commit && (mat_ad == LAST_A);
    assign pop      = (cnt_q != '0) && out_ready;
    assign full     = (cnt_q == FULL_CNT);
    assign push_ok  = push && (!full || pop);

    always_comb begin
        st_d    = st_q;
        ad_d    = ad_q;
        st_d[0] = is_store_in;
        ad_d[0] = addr;
        for (int i = 1; i < WB_LAT; i++) begin
            st_d[i] = st_q[i-1];
            ad_d[i] = ad_q[i-1];
        end
    end

    always_comb begin
        rd_d   = regs_q[rd_addr];
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        drop_d = bad;
        ovf_d  = ovf_q | (push && !push_ok);
        wbc_d  = wbc_q;
        if (commit && (waddr == rd_addr)) begin
            rd_d = alu_result;
        end
        if (commit && (wbc_q != 8'hFF)) begin
            wbc_d = wbc_q + 8'd1;
        end
        if (push_ok) begin
            wp_d = ptr_inc(wp_q);
        end
        if (pop) begin
            rp_d = ptr_inc(rp_q);
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= '0;
            ad_q   <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            drop_q <= 1'b0;
            ovf_q  <= 1'b0;
            wbc_q  <= '0;
        end else begin
            st_q   <= st_d;
            ad_q   <= ad_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
            wbc_q  <= wbc_d;
        end
    end

    // Storage arrays carry no reset: register contents must survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            regs_q[waddr] <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wp_q] <= alu_result;
        end
    end

    assign rd_data   = rd_q;
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? fifo_q[rp_q] : '0;
    assign drop      = drop_q;
    assign overflow  = ovf_q;
    assign wb_count  = wbc_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic against a cycle-stamped
// reference model; FIFO output values are scoreboarded and checked by a separate monitor.
module tb_writeback_unit;

    localparam int NREGS     = 32;
    localparam int WB_LAT    = 2;
    localparam int OUT_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_store_in = 1'b0;
    logic [11:0] addr = '0;
    logic [15:0] alu_result = '0;
    logic [4:0]  rd_addr = '0;
    logic        out_ready = 1'b0;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        drop;
    logic        overflow;
    logic [7:0]  wb_count;

    writeback_unit #(.NREGS(NREGS), .WB_LAT(WB_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst(rst), .is_store_in(is_store_in), .addr(addr),
        .alu_result(alu_result), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop(drop), .overflow(overflow), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: stores are stamped with the cycle in which they mature.
    typedef struct packed {
        int          due;
        logic [11:0] a;
    } pend_t;

    pend_t       pend[$];
    logic [15:0] mregs [NREGS];
    bit          mknown [NREGS];
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    int          mwb = 0;
    bit          movf = 0;
    bit          mdrop = 0;
    logic [15:0] mrd = '0;
    bit          mrd_known = 1;
    int          cyc = 0;

    task automatic model_edge();
        bit          mat;
        bit          commit;
        logic [11:0] ma;
        mat = 0;
        ma  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            mat = 1;
            ma  = pend[0].a;
            void'(pend.pop_front());
        end
        if (!rst) begin
            pend.delete();
            mq.delete();
            sb.delete();
            mwb = 0; movf = 0; mdrop = 0; mrd = '0; mrd_known = 1;
        end else begin
            commit = mat && (int'(ma) < NREGS);
            mdrop  = mat && (int'(ma) >= NREGS);
            if (commit && ma[4:0] == rd_addr) begin
                mrd = alu_result; mrd_known = 1;
            end else begin
                mrd = mregs[rd_addr]; mrd_known = mknown[rd_addr];
            end
            if (commit) begin
                mregs[ma[4:0]]  = alu_result;
                mknown[ma[4:0]] = 1;
                if (mwb < 255) mwb++;
            end
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (commit && int'(ma) == NREGS - 1) begin
                if (mq.size() < OUT_DEPTH) begin
                    mq.push_back(alu_result);
                    sb.push_back(alu_result);
                end else begin
                    movf = 1;
                end
            end
            if (is_store_in) pend.push_back('{cyc + WB_LAT, addr});
        end
        cyc++;
    endtask

    task automatic check_outputs();
        if (mrd_known) chk("rd_data", rd_data, mrd);
        chk("drop", drop, mdrop);
        chk("overflow", overflow, movf);
        chk("wb_count", wb_count, 32'(mwb));
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() == 0) chk("out_data_idle", out_data, 0);
    endtask

    task automatic cycle(input bit r, input bit st, input logic [11:0] a, input logic [15:0] alu,
                         input logic [4:0] ra, input bit rdy);
        rst = r; is_store_in = st; addr = a; alu_result = alu; rd_addr = ra; out_ready = rdy;
        @(negedge clk); #1;
        model_edge();
        @(posedge clk); #2;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy, input logic [4:0] ra);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 12'd0, 16'($urandom), ra, rdy);
    endtask

    logic [11:0] qa[$];
    logic [15:0] qv[$];

    task automatic push_st(input logic [11:0] a, input logic [15:0] v);
        qa.push_back(a);
        qv.push_back(v);
    endtask

    // Issues queued stores back to back; each value is presented WB_LAT cycles after its intent.
    task automatic run_q(input bit rdy, input int ra);
        int          n;
        logic [15:0] alu;
        logic [4:0]  r;
        n = qa.size();
        for (int i = 0; i < n + WB_LAT; i++) begin
            alu = (i >= WB_LAT) ? qv[i-WB_LAT] : 16'($urandom);
            r   = (ra < 0) ? 5'($urandom) : 5'(ra);
            cycle(1'b1, i < n, (i < n) ? qa[i] : 12'd0, alu, r, rdy);
        end
        qa.delete();
        qv.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"}, rd_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_odata"}, out_data, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_cnt"}, wb_count, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted output and checks stalled outputs hold.
    bit          hold_prev = 0;
    logic [15:0] held = '0;
    logic [15:0] exp_v;

    initial begin
        forever begin
            @(negedge clk);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            hold_prev = out_valid && !out_ready && rst;
            held      = out_data;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_pop: got %h expected no output at %0t", out_data, $time);
                end else begin
                    exp_v = sb.pop_front();
                    chk("out_data", out_data, exp_v);
                end
            end
        end
    end

    int          base;
    logic [15:0] saved0;
    logic [11:0] ra_a;
    int          sel;

    initial begin
        cycle(1'b0, 1'b0, 12'd0, 16'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 12'd0, 16'd0, 5'd0, 1'b0);
        chk_reset_outputs("reset");

        for (int i = 0; i < NREGS; i++) push_st(12'(i), 16'($urandom));
        run_q(1'b1, -1);
        idle(2, 1'b1, 5'd0);

        // Single store, read in the commit cycle returns the new value.
        base = mwb;
        cycle(1'b1, 1'b1, 12'd5, 16'($urandom), 5'($urandom), 1'b1);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'($urandom), 1'b1);
        cycle(1'b1, 1'b0, 12'd0, 16'hBEEF, 5'd5, 1'b1);
        chk("sc1_rd", rd_data, 16'hBEEF);
        chk("sc1_cnt", wb_count, 32'(base + 1));

        base = mwb;
        push_st(12'd3, 16'h0001);
        push_st(12'd4, 16'h0002);
        push_st(12'd3, 16'h0003);
        run_q(1'b1, -1);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd3, 1'b1);
        chk("sc2_r3", rd_data, 16'h0003);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd4, 1'b1);
        chk("sc2_r4", rd_data, 16'h0002);
        chk("sc2_cnt", wb_count, 32'(base + 3));

        // Out-of-range address whose low bits alias register 0.
        base   = mwb;
        saved0 = mregs[0];
        push_st(12'h040, 16'h1234);
        run_q(1'b1, -1);
        chk("sc4_drop", drop, 1);
        chk("sc4_cnt", wb_count, 32'(base));
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd0, 1'b1);
        chk("sc4_drop_end", drop, 0);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd0, 1'b1);
        chk("sc4_r0", rd_data, saved0);

        cycle(1'b0, 1'b0, 12'd0, 16'd0, 5'd0, 1'b1);
        push_st(12'd31, 16'h000A);
        push_st(12'd31, 16'h000B);
        push_st(12'd31, 16'h000C);
        run_q(1'b0, 31);
        chk("sc3_ovf", overflow, 1);
        chk("sc3_r31", rd_data, 16'h000C);
        chk("sc3_head", out_data, 16'h000A);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd31, 1'b1);
        chk("sc3_second", out_data, 16'h000B);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd31, 1'b1);
        chk("sc3_empty", out_valid, 0);

        // Push and pop on the same edge while full.
        cycle(1'b0, 1'b0, 12'd0, 16'd0, 5'd0, 1'b1);
        push_st(12'd31, 16'h0001);
        push_st(12'd31, 16'h0002);
        run_q(1'b0, -1);
        cycle(1'b1, 1'b1, 12'd31, 16'($urandom), 5'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 12'd0, 16'h000D, 5'($urandom), 1'b1);
        chk("sc6_ovf", overflow, 0);
        chk("sc6_valid", out_valid, 1);
        chk("sc6_head", out_data, 16'h0002);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd0, 1'b1);
        chk("sc6_last", out_data, 16'h000D);
        cycle(1'b1, 1'b0, 12'd0, 16'($urandom), 5'd0, 1'b1);
        chk("sc6_empty", out_valid, 0);

        // Reset one cycle after intent discards the store.
        push_st(12'd7, 16'h7777);
        run_q(1'b1, -1);
        cycle(1'b1, 1'b1, 12'd7, 16'($urandom), 5'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 12'd0, 16'($urandom), 5'd7, 1'b1);
        chk_reset_outputs("sc5");
        cycle(1'b1, 1'b0, 12'd0, 16'h5555, 5'd7, 1'b1);
        chk("sc5_keep", rd_data, 16'h7777);
        chk("sc5_cnt", wb_count, 0);

        for (int i = 0; i < 700; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      ra_a = 12'($urandom_range(0, NREGS - 1));
            else if (sel <= 7) ra_a = 12'(NREGS - 1);
            else               ra_a = 12'($urandom);
            cycle((i >= 300) || ($urandom_range(0, 49) != 0),
                  (i >= 300) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0),
                  ra_a, 16'($urandom), 5'($urandom), $urandom_range(0, 2) != 0);
        end
        chk("sat_cnt", wb_count, 255);
        idle(WB_LAT + OUT_DEPTH + 2, 1'b1, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
